// File: rtl/mem_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_pkg
//  Description : Shared types, STATUS bit positions, address-decode helpers
//                and the boot image for the mem_io_unit data memory.
//                The boot image is only consumed when MEMIO_BOOTROM_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_io_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OUT = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  // Bit positions inside a channel STATUS word
  localparam int c_STAT_IN_FULL_BIT   = 0;
  localparam int c_STAT_OUT_VALID_BIT = 1;

  // Constant boot image mapped at address 0 upward
  localparam int c_BOOT_IMAGE_WORDS = 5;
  localparam logic [7:0] c_BOOT_IMAGE [c_BOOT_IMAGE_WORDS] =
    '{8'h9E, 8'hBF, 8'h44, 8'hE0, 8'h00};

  // Address falls in the I/O window at the top of the map
  function automatic logic is_io(input logic [31:0] a, input logic [31:0] base);
    return a >= base;
  endfunction

  // Channel number owning an I/O address (each channel spans two words)
  function automatic logic [31:0] chan_of(input logic [31:0] a, input logic [31:0] base);
    return (a - base) >> 1;
  endfunction

  // Odd offsets inside the window are STATUS words, even ones are DATA
  function automatic logic is_status(input logic [31:0] a, input logic [31:0] base);
    return ((a - base) & 32'd1) != 32'd0;
  endfunction

  // Boot image lookup; words beyond the image read as zero
  function automatic logic [7:0] boot_word(input logic [31:0] a);
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < c_BOOT_IMAGE_WORDS; i++) begin
      if (a == 32'(i)) w = c_BOOT_IMAGE[i];
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_chan.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_chan
//  Description : One memory-mapped I/O channel: an input latch filled by a
//                valid/ready producer and drained by CPU reads, plus an output
//                register loaded by CPU writes and drained by a consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_io_chan #(
  parameter int DW = 8
) (
  input  logic          tclk,
  input  logic          rst,
  // producer side
  input  logic [DW-1:0] i_in_data,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  // CPU side of the input latch
  output logic          o_in_full,
  output logic [DW-1:0] o_in_latch,
  input  logic          i_rd_clr,
  // CPU side of the output register (only pulsed while the register is empty)
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  // consumer side
  output logic [DW-1:0] o_out_data,
  output logic          o_out_valid,
  input  logic          i_out_ready
);

  logic          r_in_full;
  logic [DW-1:0] r_in_latch;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;
  logic          w_capture;

  // Ready is forced low during reset so nothing is captured into a latch being cleared
  assign o_in_ready  = ~r_in_full & ~rst;
  assign w_capture   = i_in_valid & o_in_ready;
  assign o_in_full   = r_in_full;
  assign o_in_latch  = r_in_latch;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;

  // Input latch: capture when empty, empty on a CPU DATA read
  always_ff @(posedge tclk) begin
    if (rst) begin
      r_in_full  <= 1'b0;
      r_in_latch <= '0;
    end else if (w_capture) begin
      r_in_latch <= i_in_data;
      r_in_full  <= 1'b1;
    end else if (i_rd_clr) begin
      r_in_full  <= 1'b0;
    end
  end

  // Output register: CPU load, consumer drain
  always_ff @(posedge tclk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (i_wr_en) begin
      r_out_data  <= i_wr_data;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_io_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_unit
//  Description : Data memory for the accumulator CPU with N_IO handshaked
//                I/O channels mapped at the top of the address space,
//                accessed over a req/ack bus.
//                Optional feature macro: MEMIO_BOOTROM_EN - overlays the
//                package boot image on addresses 0..BOOT_WORDS-1 (read-only).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_io_unit #(
  parameter int AW         = 5,
  parameter int DW         = 8,
  parameter int N_IO       = 2,
  parameter int BOOT_WORDS = 5
) (
  input  logic               tclk,
  input  logic               rst,
  input  logic               req,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [DW-1:0]      wdata,
  output logic               ack,
  output logic [DW-1:0]      rdata,
  input  logic [N_IO*DW-1:0] in_data,
  input  logic [N_IO-1:0]    in_valid,
  output logic [N_IO-1:0]    in_ready,
  output logic [N_IO*DW-1:0] out_data,
  output logic [N_IO-1:0]    out_valid,
  input  logic [N_IO-1:0]    out_ready
);
  import mem_io_pkg::*;

  localparam int unsigned c_IO_BASE = (1 << AW) - 2 * N_IO;

  state_t        r_state;
  state_t        w_next;
  logic          r_ack;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_mem [0:c_IO_BASE-1];

  logic [31:0]     w_addr32;
  logic            w_is_io;
  logic            w_is_stat;
  logic            w_sel_busy;
  logic            w_exec;
  logic            w_ram_we;
  logic [N_IO-1:0] w_sel;
  logic [N_IO-1:0] w_in_full;
  logic [N_IO-1:0] w_wr_en;
  logic [N_IO-1:0] w_rd_clr;
  logic [DW-1:0]   w_in_latch [N_IO];
  logic [DW-1:0]   w_io_rdata;
  logic [DW-1:0]   w_ram_rdata;

  assign w_addr32  = 32'(addr);
  assign w_is_io   = is_io(w_addr32, 32'(c_IO_BASE));
  assign w_is_stat = is_status(w_addr32, 32'(c_IO_BASE));
  assign ack       = r_ack;
  assign rdata     = r_rdata;

  // One-hot channel select for the addressed I/O word, and whether its output is still full
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_IO; k++) begin
      w_sel[k] = w_is_io && (chan_of(w_addr32, 32'(c_IO_BASE)) == 32'(k));
    end
    w_sel_busy = |(w_sel & out_valid);
  end

  // Next-state logic; w_exec marks the cycle in which the access takes effect
  always_comb begin
    w_next = r_state;
    w_exec = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          // A DATA write to a full output register must wait for the consumer
          if (w_is_io && !w_is_stat && we && w_sel_busy) begin
            w_next = ST_WAIT_OUT;
          end else begin
            w_exec = 1'b1;
            w_next = ST_DONE;
          end
        end
      end
      ST_WAIT_OUT: begin
        if (!w_sel_busy) begin
          w_exec = 1'b1;
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Decode the executing access into RAM write, channel load or latch drain strobes
  always_comb begin
    w_ram_we = 1'b0;
    w_wr_en  = '0;
    w_rd_clr = '0;
    if (w_exec && !rst) begin
      if (!w_is_io) begin
`ifdef MEMIO_BOOTROM_EN
        w_ram_we = we && (w_addr32 >= 32'(BOOT_WORDS));
`else
        w_ram_we = we;
`endif
      end else if (!w_is_stat) begin
        if (we) w_wr_en  = w_sel;
        else    w_rd_clr = w_sel;
      end
      // STATUS writes fall through: acknowledged with no effect
    end
  end

  // Read data for the addressed I/O word (latch value or STATUS)
  always_comb begin
    w_io_rdata = '0;
    for (int k = 0; k < N_IO; k++) begin
      if (w_sel[k]) begin
        if (w_is_stat) begin
          w_io_rdata[c_STAT_OUT_VALID_BIT] = out_valid[k];
          w_io_rdata[c_STAT_IN_FULL_BIT]   = w_in_full[k];
        end else begin
          w_io_rdata = w_in_latch[k];
        end
      end
    end
  end

  // Read data for the RAM region, with the boot image overlay when enabled
  always_comb begin
    w_ram_rdata = r_mem[addr];
`ifdef MEMIO_BOOTROM_EN
    if (w_addr32 < 32'(BOOT_WORDS)) w_ram_rdata = DW'(boot_word(w_addr32));
`endif
  end

  // Sequencer state, completion pulse and read-data register
  always_ff @(posedge tclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_exec;
      if (w_exec && !we) r_rdata <= w_is_io ? w_io_rdata : w_ram_rdata;
    end
  end

  // RAM array; contents deliberately survive reset
  always_ff @(posedge tclk) begin
    if (w_ram_we) r_mem[addr] <= wdata;
  end

  for (genvar k = 0; k < N_IO; k++) begin : g_chan
    mem_io_chan #(
      .DW(DW)
    ) u_chan (
      .tclk        (tclk),
      .rst         (rst),
      .i_in_data   (in_data[k*DW +: DW]),
      .i_in_valid  (in_valid[k]),
      .o_in_ready  (in_ready[k]),
      .o_in_full   (w_in_full[k]),
      .o_in_latch  (w_in_latch[k]),
      .i_rd_clr    (w_rd_clr[k]),
      .i_wr_en     (w_wr_en[k]),
      .i_wr_data   (wdata),
      .o_out_data  (out_data[k*DW +: DW]),
      .o_out_valid (out_valid[k]),
      .i_out_ready (out_ready[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_io_unit
//  Description : Scoreboard bench for mem_io_unit (AW=5, DW=8, N_IO=2).
//                Honours MEMIO_BOOTROM_EN when defined for the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_unit;
  localparam int AW      = 5;
  localparam int DW      = 8;
  localparam int N_IO    = 2;
  localparam int IO_BASE = 28;

  logic               tclk      = 1'b0;
  logic               rst       = 1'b1;
  logic               req       = 1'b0;
  logic               we        = 1'b0;
  logic [AW-1:0]      addr      = '0;
  logic [DW-1:0]      wdata     = '0;
  logic               ack;
  logic [DW-1:0]      rdata;
  logic [N_IO*DW-1:0] in_data   = '0;
  logic [N_IO-1:0]    in_valid  = '0;
  logic [N_IO-1:0]    in_ready;
  logic [N_IO*DW-1:0] out_data;
  logic [N_IO-1:0]    out_valid;
  logic [N_IO-1:0]    out_ready = '0;

  always #5 tclk = ~tclk;

  mem_io_unit #(.AW(AW), .DW(DW), .N_IO(N_IO), .BOOT_WORDS(5)) dut (
    .tclk(tclk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         chk;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] oq0 [$];
  logic [7:0] oq1 [$];
  logic [7:0] mem_m [0:IO_BASE-1];
  bit         mem_known [0:IO_BASE-1];
  logic [7:0] latch_m [2];
  bit         full_m [2];
  int         mode [2];   // consumer ready: 0 low, 1 high, 2 random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer ready driver, updated just after each rising edge
  always @(posedge tclk) begin
    #2;
    for (int k = 0; k < 2; k++)
      out_ready[k] = (mode[k] == 2) ? 1'($urandom_range(0, 1)) : (mode[k] == 1);
  end

  // Monitor: bus completions and consumer transfers against the scoreboard
  always @(negedge tclk) begin
    exp_t       e;
    logic [7:0] v;
    if (ack) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL ack_unexpected: got ack=1 required ack=0");
      end else begin
        e = exp_q.pop_front();
        if (e.chk) chk("rdata", 32'(rdata), 32'(e.val));
        else n_vec++;
      end
    end
    if (out_valid[0] && out_ready[0]) begin
      if (oq0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out0_unexpected: got %0h required none", out_data[7:0]);
      end else begin
        v = oq0.pop_front();
        chk("out_data0", 32'(out_data[7:0]), 32'(v));
      end
    end
    if (out_valid[1] && out_ready[1]) begin
      if (oq1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out1_unexpected: got %0h required none", out_data[15:8]);
      end else begin
        v = oq1.pop_front();
        chk("out_data1", 32'(out_data[15:8]), 32'(v));
      end
    end
  end

  task automatic do_access(input bit w, input int a, input logic [7:0] d,
                           input bit chk_rd, input logic [7:0] exp_rd, input int exp_lat);
    int   cnt;
    exp_t e;
    @(posedge tclk); #1;
    req = 1'b1; we = w; addr = AW'(a); wdata = d;
    e.chk = chk_rd; e.val = exp_rd;
    exp_q.push_back(e);
    cnt = 0;
    do begin
      @(negedge tclk);
      cnt++;
    end while (!ack && cnt < 300);
    if (!ack) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: got no ack after %0d cycles at addr %0d", cnt, a);
    end else if (exp_lat > 0) begin
      chk("ack_latency", 32'(cnt), 32'(exp_lat));
    end
    @(posedge tclk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  function automatic bit boot_range(input int a);
`ifdef MEMIO_BOOTROM_EN
    return a < 5;
`else
    return 1'b0;
`endif
  endfunction

  task automatic ram_write(input int a, input logic [7:0] d);
    do_access(1'b1, a, d, 1'b0, 8'h00, 2);
    if (!boot_range(a)) begin
      mem_m[a] = d;
      mem_known[a] = 1'b1;
    end
  endtask

  task automatic ram_read(input int a);
    do_access(1'b0, a, 8'h00, 1'b1, mem_m[a], 2);
  endtask

  task automatic data_write(input int k, input logic [7:0] d, input int lat);
    if (k == 0) oq0.push_back(d); else oq1.push_back(d);
    do_access(1'b1, IO_BASE + 2*k, d, 1'b0, 8'h00, lat);
  endtask

  task automatic data_read(input int k);
    logic [7:0] e;
    e = latch_m[k];
    full_m[k] = 1'b0;
    do_access(1'b0, IO_BASE + 2*k, 8'h00, 1'b1, e, 2);
  endtask

  // Consumers are parked for the read so the expected out_valid is stable
  task automatic status_read(input int k);
    int         m0, m1;
    logic [7:0] e;
    @(posedge tclk); #1;
    m0 = mode[0]; m1 = mode[1];
    mode[0] = 0; mode[1] = 0;
    e = 8'h00;
    e[1] = (k == 0) ? (oq0.size() != 0) : (oq1.size() != 0);
    e[0] = full_m[k];
    do_access(1'b0, IO_BASE + 2*k + 1, 8'h00, 1'b1, e, 2);
    mode[0] = m0; mode[1] = m1;
  endtask

  task automatic inject(input int k, input logic [7:0] v);
    @(posedge tclk); #1;
    chk("in_ready_empty", 32'(in_ready[k]), 32'(1));
    in_valid[k] = 1'b1;
    in_data[k*8 +: 8] = v;
    @(posedge tclk); #1;
    in_valid[k] = 1'b0;
    full_m[k] = 1'b1;
    latch_m[k] = v;
    @(negedge tclk);
    chk("in_ready_full", 32'(in_ready[k]), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, k, a, c;
    logic [7:0] d;
    for (int i = 0; i < IO_BASE; i++) begin
      mem_m[i] = 8'h00;
      mem_known[i] = 1'b0;
    end
`ifdef MEMIO_BOOTROM_EN
    mem_m[0] = 8'h9E; mem_m[1] = 8'hBF; mem_m[2] = 8'h44; mem_m[3] = 8'hE0; mem_m[4] = 8'h00;
    for (int i = 0; i < 5; i++) mem_known[i] = 1'b1;
`endif
    latch_m[0] = 8'h00; latch_m[1] = 8'h00;
    full_m[0] = 1'b0; full_m[1] = 1'b0;
    mode[0] = 1; mode[1] = 1;

    // Reset state
    repeat (2) @(negedge tclk);
    chk("in_ready_in_reset", 32'(in_ready), 32'(0));
    @(posedge tclk); #1;
    rst = 1'b0;
    @(negedge tclk);
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(3));

    // RAM write then read
    ram_write(7, 8'h5A);
    ram_read(7);

`ifdef MEMIO_BOOTROM_EN
    ram_read(0);
    ram_write(2, 8'hFF);
    ram_read(2);
`endif

    // Input channel 1
    inject(1, 8'h3C);
    status_read(1);
    data_read(1);
    status_read(1);
    @(negedge tclk);
    chk("in_ready1_back", 32'(in_ready[1]), 32'(1));

    // Output backpressure on channel 0
    mode[0] = 0;
    data_write(0, 8'h11, 2);
    @(negedge tclk);
    chk("out_valid0_loaded", 32'(out_valid[0]), 32'(1));
    chk("out_data0_loaded", 32'(out_data[7:0]), 32'(8'h11));
    fork
      data_write(0, 8'h22, 0);
      begin
        repeat (3) begin
          @(negedge tclk);
          chk("stall_no_ack", 32'(ack), 32'(0));
        end
        @(posedge tclk); #1;
        mode[0] = 1;
        c = 0;
        do begin
          @(negedge tclk);
          c++;
        end while (!ack && c < 50);
        chk("stall_release_latency", 32'(c), 32'(3));
      end
    join

    // Status write is acknowledged and has no effect
    do_access(1'b1, IO_BASE + 1, 8'hFF, 1'b0, 8'h00, 2);
    status_read(0);

    // Reset while a write waits on a full channel 1
    mode[1] = 0;
    data_write(1, 8'h33, 2);
    @(posedge tclk); #1;
    req = 1'b1; we = 1'b1; addr = AW'(IO_BASE + 2); wdata = 8'h44;
    repeat (3) @(negedge tclk);
    @(posedge tclk); #1;
    rst = 1'b1; req = 1'b0; we = 1'b0;
    repeat (2) @(negedge tclk);
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(0));
    oq0.delete(); oq1.delete();
    full_m[0] = 1'b0; full_m[1] = 1'b0;
    @(posedge tclk); #1;
    rst = 1'b0; mode[1] = 1;
    repeat (3) @(negedge tclk);
    chk("postrst_no_ack", 32'(ack), 32'(0));
    ram_read(7);

    // Randomised mix
    mode[0] = 2; mode[1] = 2;
    for (int i = 0; i < 160; i++) begin
      op = $urandom_range(0, 6);
      k  = $urandom_range(0, 1);
      a  = $urandom_range(0, IO_BASE - 1);
      d  = 8'($urandom);
      case (op)
        0: ram_write(a, d);
        1: if (mem_known[a]) ram_read(a); else ram_write(a, d);
        2: if (!full_m[k]) inject(k, d); else data_read(k);
        3: if (full_m[k]) data_read(k); else inject(k, d);
        4: data_write(k, d, 0);
        5: status_read(k);
        default: do_access(1'b1, IO_BASE + 2*k + 1, d, 1'b0, 8'h00, 2);
      endcase
    end

    // Drain consumers and confirm nothing is left outstanding
    mode[0] = 1; mode[1] = 1;
    repeat (6) @(negedge tclk);
    chk("drain_q0", 32'(oq0.size()), 32'(0));
    chk("drain_q1", 32'(oq1.size()), 32'(0));
    chk("drain_exp", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
